// File: rtl/div_arbiter.sv
// Round-robin front end sharing one radix-2 restoring divider between two requesters.
// One operation at a time: accept, WIDTH iterations, one DONE cycle, back to IDLE.
module div_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               inp_clk,
    input  logic               inp_rst,
    input  logic               inp_req0,
    input  logic               inp_req1,
    input  logic [WIDTH-1:0]   inp_a0,
    input  logic [WIDTH-1:0]   inp_b0,
    input  logic [WIDTH-1:0]   inp_a1,
    input  logic [WIDTH-1:0]   inp_b1,
    output logic               out_ack0,
    output logic               out_ack1,
    output logic               out_done0,
    output logic               out_done1,
    output logic [2*WIDTH-1:0] out_result0,
    output logic [2*WIDTH-1:0] out_result1,
    output logic               out_busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e state_q, state_d;

    logic                 last_q;
    logic                 sel_q;
    logic [CntW-1:0]      count_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     d_q;
    logic                 ack0_q, ack1_q, done0_q, done1_q;
    logic [2*WIDTH-1:0]   result0_q, result1_q;

    logic                 grant_valid;
    logic                 grant_port;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     q_next;
    logic                 last_iter;

    // Both requesting: take the port that was not served last.
    always_comb begin
        grant_valid = inp_req0 | inp_req1;
        grant_port  = (inp_req0 & inp_req1) ? ~last_q : inp_req1;
    end

    // The stored remainder is always below the divisor, so it fits WIDTH bits;
    // a restore only happens when rem_shift < d, hence its top bit is then zero.
    always_comb begin
        rem_shift = {rem_q, q_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, d_q};
        rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next    = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        last_iter = (count_q == CntW'(1));
    end

    // State register
    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_valid) state_d = StDiv;
            StDiv:   if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath, arbitration pointer and registered pulses
    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            count_q   <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            d_q       <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            result0_q <= '0;
            result1_q <= '0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        sel_q   <= grant_port;
                        last_q  <= grant_port;
                        rem_q   <= '0;
                        q_q     <= grant_port ? inp_a1 : inp_a0;
                        d_q     <= grant_port ? inp_b1 : inp_b0;
                        count_q <= CntW'(WIDTH);
                        ack0_q  <= ~grant_port;
                        ack1_q  <= grant_port;
                    end
                end
                StDiv: begin
                    rem_q   <= rem_next;
                    q_q     <= q_next;
                    count_q <= count_q - CntW'(1);
                    if (last_iter) begin
                        if (sel_q) begin
                            result1_q <= {q_next, rem_next};
                            done1_q   <= 1'b1;
                        end else begin
                            result0_q <= {q_next, rem_next};
                            done0_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        out_busy    = (state_q != StIdle);
        out_ack0    = ack0_q;
        out_ack1    = ack1_q;
        out_done0   = done0_q;
        out_done1   = done1_q;
        out_result0 = result0_q;
        out_result1 = result1_q;
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed table, arbitration/reset sequences,
// and random operations checked against a plain-arithmetic divide model.
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, done0, done1, busy;
    logic [31:0] res0, res1;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_res0, exp_res1;

    always #5 clk = ~clk;

    div_arbiter #(.WIDTH(16)) dut (
        .inp_clk     (clk),
        .inp_rst     (rst),
        .inp_req0    (req0),
        .inp_req1    (req1),
        .inp_a0      (a0),
        .inp_b0      (b0),
        .inp_a1      (a1),
        .inp_b1      (b1),
        .out_ack0    (ack0),
        .out_ack1    (ack1),
        .out_done0   (done0),
        .out_done1   (done1),
        .out_result0 (res0),
        .out_result1 (res1),
        .out_busy    (busy)
    );

    typedef struct {
        bit          port;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q, r;
        if (b == 16'd0) return {16'hFFFF, a};
        q = a / b;
        r = a % b;
        return {q, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input bit p);
        return p ? ack1 : ack0;
    endfunction

    function automatic logic done_of(input bit p);
        return p ? done1 : done0;
    endfunction

    // Issue one request from an idle block and follow it to completion.
    task automatic do_op(input bit port, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input bit scramble, input string name);
        int cyc;
        if (port) begin a1 = a; b1 = b; req1 = 1'b1; end
        else begin a0 = a; b0 = b; req0 = 1'b1; end
        cyc = 0;
        do begin step(); cyc++; end while (ack_of(port) !== 1'b1 && cyc < 40);
        chk1({name, "_ack"}, ack_of(port), 1'b1);
        chk1({name, "_ack_other"}, ack_of(!port), 1'b0);
        chk1({name, "_busy"}, busy, 1'b1);
        if (port) req1 = 1'b0; else req0 = 1'b0;
        cyc = 0;
        do begin
            if (scramble) begin
                a0 = 16'($urandom);
                b0 = 16'($urandom);
            end
            step();
            cyc++;
        end while (done_of(port) !== 1'b1 && cyc < 40);
        chk({name, "_latency"}, cyc, 16);
        if (port) exp_res1 = exp; else exp_res0 = exp;
        chk({name, "_res0"}, res0, exp_res0);
        chk({name, "_res1"}, res1, exp_res1);
        step();
        chk1({name, "_done_drop"}, done_of(port), 1'b0);
        chk1({name, "_idle"}, busy, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        int seen;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        exp_res0 = '0; exp_res1 = '0;

        vecs.push_back('{1'b0, 16'd100,   16'd7,      32'h000E_0002});
        vecs.push_back('{1'b1, 16'hFFFF,  16'd1,      32'hFFFF_0000});
        vecs.push_back('{1'b0, 16'd3,     16'hFFFF,   32'h0000_0003});
        vecs.push_back('{1'b0, 16'd5,     16'd0,      32'hFFFF_0005});
        vecs.push_back('{1'b1, 16'd0,     16'd5,      32'h0000_0000});
        vecs.push_back('{1'b0, 16'hFFFF,  16'hFFFF,   32'h0001_0000});
        vecs.push_back('{1'b1, 16'd1000,  16'd10,     32'h0064_0000});
        vecs.push_back('{1'b1, 16'h1234,  16'h0012,   32'h0102_0010});

        step(); step();
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_done0", done0, 1'b0);
        chk1("rst_done1", done1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_res0", res0, 32'h0);
        chk("rst_res1", res1, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Both requests held through reset: reset wins, then port 0 then port 1.
        rst = 1'b1;
        a0 = 16'd100; b0 = 16'd7; a1 = 16'hFFFF; b1 = 16'd1;
        req0 = 1'b1; req1 = 1'b1;
        step();
        exp_res0 = '0; exp_res1 = '0;
        chk1("arb_rst_ack0", ack0, 1'b0);
        chk1("arb_rst_ack1", ack1, 1'b0);
        chk1("arb_rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        chk1("arb1_ack0", ack0, 1'b1);
        chk1("arb1_ack1", ack1, 1'b0);
        req0 = 1'b0;
        repeat (16) step();
        chk1("arb1_done0", done0, 1'b1);
        chk("arb1_res0", res0, 32'h000E_0002);
        chk("arb1_res1", res1, 32'h0);
        step();
        chk1("arb1_idle", busy, 1'b0);
        chk1("arb1_ack1_early", ack1, 1'b0);
        step();
        chk1("arb2_ack1_e18", ack1, 1'b1);
        req1 = 1'b0;
        repeat (16) step();
        chk1("arb2_done1", done1, 1'b1);
        chk("arb2_res1", res1, 32'hFFFF_0000);
        step();

        // Second contest: last grant was port 1, so port 0 wins.
        a0 = 16'd3; b0 = 16'hFFFF; a1 = 16'd1000; b1 = 16'd10;
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk1("arb3_ack0", ack0, 1'b1);
        chk1("arb3_ack1", ack1, 1'b0);
        req0 = 1'b0;
        repeat (16) step();
        chk("arb3_res0", res0, 32'h0000_0003);
        step(); step();
        chk1("arb4_ack1", ack1, 1'b1);
        req1 = 1'b0;
        repeat (16) step();
        chk("arb4_res1", res1, 32'h0064_0000);
        step();
        exp_res0 = 32'h0000_0003;
        exp_res1 = 32'h0064_0000;

        // Port 0 twice in a row with port 1 idle.
        do_op(1'b0, 16'd50, 16'd6, 32'h0008_0002, 1'b0, "rep0a");
        do_op(1'b0, 16'd7,  16'd2, 32'h0003_0001, 1'b0, "rep0b");

        // Operands wiggled during DIV must not disturb the result.
        do_op(1'b0, 16'd100, 16'd7, 32'h000E_0002, 1'b1, "iso");

        // Reset after iteration 8.
        a0 = 16'h1234; b0 = 16'h0012; req0 = 1'b1;
        step();
        chk1("mid_ack0", ack0, 1'b1);
        req0 = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_res0 = '0; exp_res1 = '0;
        chk1("mid_done0", done0, 1'b0);
        chk1("mid_busy", busy, 1'b0);
        chk("mid_res0", res0, 32'h0);
        chk("mid_res1", res1, 32'h0);
        seen = 0;
        repeat (20) begin
            step();
            if (done0 === 1'b1 || done1 === 1'b1 || busy === 1'b1) seen++;
        end
        chk("mid_quiet", seen, 0);
        do_op(1'b0, 16'h1234, 16'h0012, 32'h0102_0010, 1'b0, "mid_after");

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            bit          p;
            logic [15:0] ra, rb;
            int unsigned kind;
            p    = 1'($urandom_range(0, 1));
            ra   = 16'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 0) rb = 16'd0;
            else if (kind == 1) rb = 16'($urandom_range(1, 15));
            else rb = 16'($urandom);
            do_op(p, ra, rb, ref_div(ra, rb), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
